// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver; in i_clock/i_reset_n/i_rx_serial, out o_rx_dv/o_rx_byte/o_rx_frame_err/o_rx_active
module uart_rx #(
  parameter int CLKS_PER_BIT = 8700
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_frame_err,
  output logic       o_rx_active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP, BRK} state_t;
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift_reg, shift_n, byte_n;
  logic dv_n, err_n, active_n, rx_m, rx_s;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      shift_reg <= '0;
      o_rx_byte <= '0;
      o_rx_dv <= 1'b0;
      o_rx_frame_err <= 1'b0;
      o_rx_active <= 1'b0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      state <= state_n;
      count <= count_n;
      idx <= idx_n;
      shift_reg <= shift_n;
      o_rx_byte <= byte_n;
      o_rx_dv <= dv_n;
      o_rx_frame_err <= err_n;
      o_rx_active <= active_n;
      rx_m <= i_rx_serial;
      rx_s <= rx_m;
    end
  always_comb begin
    state_n = IDLE;
    count_n = '0;
    idx_n = idx;
    shift_n = shift_reg;
    byte_n = o_rx_byte;
    dv_n = 1'b0;
    err_n = 1'b0;
    active_n = o_rx_active;
    case (state)
      IDLE: begin
        idx_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: begin
        count_n = count + CW'(1);
        state_n = START;
        if (count == HALF) begin
          count_n = '0;
          active_n = !rx_s;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        count_n = count + CW'(1);
        state_n = DATA;
        if (count == LAST) begin
          count_n = '0;
          shift_n[idx] = rx_s;
          idx_n = idx + 3'd1;
          state_n = (idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP: begin
        count_n = count + CW'(1);
        state_n = STOP;
        if (count == LAST) begin
          count_n = '0;
          active_n = 1'b0;
          dv_n = rx_s;
          err_n = !rx_s;
          byte_n = rx_s ? shift_reg : o_rx_byte;
          state_n = rx_s ? CLEANUP : BRK;
        end
      end
      CLEANUP: state_n = IDLE;
      BRK: state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
endmodule
